// File: rtl/mem_stage.sv
// Pipeline MEM stage: issues one data-memory access per load/store, stalls upstream until it completes.
// Optional macro MEM_STAGE_TIMEOUT_EN forces completion after TIMEOUT WAIT cycles without mem_ack.
module mem_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        rst,
    input  logic [73:0] EXMEM,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [70:0] MEMWB,
    output logic        err
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [31:0] alu_out_s;
    logic [31:0] read_data2_s;
    logic [4:0]  write_reg_s;
    logic        reg_write_s;
    logic        mem_read_s;
    logic        mem_write_s;
    logic        mem_to_reg_s;
    logic        op_s;
    logic        unused_bits_s;

    state_t      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [70:0] memwb_q, memwb_d;
    logic        err_q, err_d;
`ifdef MEM_STAGE_TIMEOUT_EN
    logic [7:0]  cnt_q, cnt_d;
`endif

    assign alu_out_s     = EXMEM[32:1];
    assign read_data2_s  = EXMEM[64:33];
    assign write_reg_s   = EXMEM[69:65];
    assign reg_write_s   = EXMEM[70];
    assign mem_read_s    = EXMEM[71];
    assign mem_write_s   = EXMEM[72];
    assign mem_to_reg_s  = EXMEM[73];
    assign op_s          = mem_read_s | mem_write_s;
    assign unused_bits_s = ^{EXMEM[0], TMO_LAST};

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign MEMWB     = memwb_q;
    assign err       = err_q;

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        memwb_d     = memwb_q;
        err_d       = err_q;
        stall       = 1'b0;
`ifdef MEM_STAGE_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (op_s) begin
                    stall       = 1'b1;
                    state_d     = S_WAIT;
                    mem_req_d   = 1'b1;
                    mem_we_d    = mem_write_s;
                    mem_addr_d  = {alu_out_s[31:2], 2'b00};
                    mem_wdata_d = read_data2_s;
                    memwb_d     = 71'd0;
                    if (alu_out_s[1:0] != 2'b00) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                end else begin
                    memwb_d = {mem_to_reg_s, reg_write_s, write_reg_s, alu_out_s, 32'h0000_0000};
                end
            end
            S_WAIT: begin
                if (mem_ack) begin
                    // EXMEM is still held, so its fields are the ones for this access
                    state_d   = S_IDLE;
                    mem_req_d = 1'b0;
                    memwb_d   = {mem_to_reg_s, reg_write_s, write_reg_s, alu_out_s,
                                 (mem_we_q ? 32'h0000_0000 : mem_rdata)};
`ifdef MEM_STAGE_TIMEOUT_EN
                    cnt_d     = 8'd0;
`endif
                end else begin
`ifdef MEM_STAGE_TIMEOUT_EN
                    if (cnt_q == TMO_LAST) begin
                        state_d   = S_IDLE;
                        mem_req_d = 1'b0;
                        memwb_d   = {mem_to_reg_s, reg_write_s, write_reg_s, alu_out_s, 32'h0000_0000};
                        err_d     = 1'b1;
                        cnt_d     = 8'd0;
                    end else begin
                        stall   = 1'b1;
                        memwb_d = 71'd0;
                        cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                    end
`else
                    stall   = 1'b1;
                    memwb_d = 71'd0;
`endif
                end
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
                memwb_d   = 71'd0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0000_0000;
            mem_wdata_q <= 32'h0000_0000;
            memwb_q     <= 71'd0;
            err_q       <= 1'b0;
`ifdef MEM_STAGE_TIMEOUT_EN
            cnt_q       <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            memwb_q     <= memwb_d;
            err_q       <= err_d;
`ifdef MEM_STAGE_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, giving max WAIT cycles without mem_ack before forced completion; legal range 1..255.
REQ-002 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port EXMEM  input  74  pipeline bundle: [0] zero, [32:1] ALUout, [64:33] ReadData2, [69:65] WriteReg, [70] RegWrite, [71] MemRead, [72] MemWrite, [73] MemtoReg.
REQ-005 SHALL have port stall  output  1  combinational; upstream holds EXMEM stable while 1.
REQ-006 SHALL have port mem_req  output  1  registered data-memory request.
REQ-007 SHALL have port mem_we  output  1  registered; 1 = write, 0 = read.
REQ-008 SHALL have port mem_addr  output  32  registered; {ALUout[31:2],2'b00}.
REQ-009 SHALL have port mem_wdata  output  32  registered; ReadData2.
REQ-010 SHALL have port mem_rdata  input  32  read data, valid when mem_ack=1.
REQ-011 SHALL have port mem_ack  input  1  one-cycle completion strobe.
REQ-012 SHALL have port MEMWB  output  71  registered: [31:0] ReadData, [63:32] ALUout, [68:64] WriteReg, [69] RegWrite, [70] MemtoReg.
REQ-013 SHALL have port err  output  1  sticky: misaligned access or timeout.

Function
REQ-014 SHALL implement FSM states IDLE and WAIT.
REQ-015 "op" SHALL mean EXMEM[71] | EXMEM[72]; if both are set, the access SHALL be a write.
REQ-016 IDLE, op=0: stall=0; MEMWB loads ALUout/WriteReg/RegWrite/MemtoReg with ReadData=0 at next edge (1-cycle latency).
REQ-017 IDLE, op=1: stall=1; at next edge go to WAIT, set mem_req=1 and load mem_we/mem_addr/mem_wdata; MEMWB loads bubble (RegWrite=0, MemtoReg=0, other fields 0).
REQ-018 WAIT, mem_ack=0: stall=1; mem_req and address/data held; MEMWB loads bubble; wait counter increments.
REQ-019 WAIT, mem_ack=1: stall=0; at the edge MEMWB loads EXMEM fields, ReadData=mem_rdata for a read (0 for a write); mem_req=0; counter=0; go to IDLE.
REQ-020 Load/store with ack in first WAIT cycle SHALL have 2-cycle latency from EXMEM presentation to MEMWB update.
REQ-021 mem_ack while in IDLE SHALL be ignored.
REQ-022 op=1 with ALUout[1:0]!=0 SHALL set err at the IDLE->WAIT edge; the access still proceeds word-aligned.
REQ-023 Wait counter SHALL be 8 bits and SHALL NOT wrap.

Reset
REQ-024 rst=1 at a rising edge SHALL force IDLE, counter=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, MEMWB=0, err=0.
REQ-025 rst SHALL abort an in-flight access (mem_req drops at that edge); a later mem_ack SHALL be ignored.
REQ-026 rst SHALL take priority over mem_ack in the same cycle.

Configuration
REQ-027 Macro MEM_STAGE_TIMEOUT_EN defined: in WAIT, when counter==TIMEOUT-1 and mem_ack=0, stall SHALL be 0 and the access SHALL complete as in REQ-019 with ReadData=32'h0, setting err.
REQ-028 Macro MEM_STAGE_TIMEOUT_EN undefined: WAIT persists indefinitely until mem_ack; no counter logic; err SHALL be set only by misalignment.

Verification
REQ-029 ALU op, EXMEM: ALUout=0x10, WriteReg=5, RegWrite=1, MemRead=0, MemWrite=0 -> stall=0; next edge MEMWB[63:32]=0x10, [68:64]=5, [69]=1, [31:0]=0.
REQ-030 Load, ALUout=0x100, MemRead=1; ack after 3 WAIT cycles with rdata=0xDEADBEEF -> stall=1 for 4 cycles; mem_addr=0x100, mem_we=0; MEMWB[31:0]=0xDEADBEEF, bubble MEMWB before.
REQ-031 Store, ALUout=0x20, ReadData2=0xCAFE0001, MemWrite=1; ack in first WAIT cycle -> mem_we=1, mem_wdata=0xCAFE0001; MEMWB update 2 cycles after presentation.
REQ-032 Load, ALUout=0x103 -> mem_addr=0x100, err=1 from the IDLE->WAIT edge until reset.
REQ-033 With MEM_STAGE_TIMEOUT_EN, TIMEOUT=4, load, no ack -> completes after 4 WAIT cycles, MEMWB[31:0]=0, err=1; without the macro -> stall stays 1 for 100 cycles.
REQ-034 rst asserted in second WAIT cycle, mem_ack pulsed one cycle later -> mem_req=0, MEMWB=0, state IDLE; ack has no effect.
